// File: rtl/vxe_txn_defs_pkg.sv
// Shared encoded-transaction vector widths and field positions for the VxEngine
// memory port; also used by the codec modules.
package vxe_txn_defs;

    localparam int unsigned REQ_TXN_W = 44;
    localparam int unsigned REQ_DAT_W = 72;
    localparam int unsigned RES_TXN_W = 9;
    localparam int unsigned RES_DAT_W = 64;

    // Request txn vector: {txnid, rnw, addr}
    localparam int unsigned TXNID_HI      = 43;
    localparam int unsigned TXNID_LO      = 38;
    localparam int unsigned TXNID_CLI_BIT = 43;
    localparam int unsigned RNW_BIT       = 37;
    localparam int unsigned ADDR_HI       = 36;
    localparam int unsigned ADDR_LO       = 0;

    // Request data vector: {data, ben}
    localparam int unsigned DATA_HI = 71;
    localparam int unsigned DATA_LO = 8;
    localparam int unsigned BEN_HI  = 7;
    localparam int unsigned BEN_LO  = 0;

    // Response txn vector: {txnid, rnw, err}
    localparam int unsigned RES_TXNID_HI = 8;
    localparam int unsigned RES_TXNID_LO = 3;
    localparam int unsigned RES_CLI_BIT  = 8;
    localparam int unsigned RES_RNW_BIT  = 2;
    localparam int unsigned ERR_HI       = 1;
    localparam int unsigned ERR_LO       = 0;

    typedef enum logic {
        CLI_C0 = 1'b0,
        CLI_C1 = 1'b1
    } cli_e;

    function automatic logic [REQ_TXN_W-1:0] tag_txn(input logic [REQ_TXN_W-1:0] txn,
                                                     input cli_e cli);
        logic [REQ_TXN_W-1:0] r;
        r = txn;
        r[TXNID_CLI_BIT] = cli;
        return r;
    endfunction

endpackage

// File: rtl/vxe_txnarb_rr.sv
// Two-way round-robin picker: one-hot grant among eligible clients, favouring
// the client not granted last; pointer moves to the winner on advance.
module vxe_txnarb_rr
    import vxe_txn_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    input  logic       advance,
    output logic [1:0] grant,
    output cli_e       ptr
);

    always_comb begin
        grant = '0;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == CLI_C1) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= CLI_C1;
        end else if (advance && (grant != '0)) begin
            ptr <= grant[1] ? CLI_C1 : CLI_C0;
        end
    end

endmodule

// File: rtl/vxe_txn_arbiter.sv
// Two-client round-robin arbiter onto one registered master port; responses are
// routed back combinationally by txnid[5]. Option: VXE_TXNARB_OSTD_LIMIT_EN.
module vxe_txn_arbiter
    import vxe_txn_defs::*;
#(
    parameter int unsigned OSTD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [REQ_TXN_W-1:0] i_c0_req_vec_txn,
    input  logic [REQ_DAT_W-1:0] i_c0_req_vec_dat,
    input  logic                 i_c0_req_vld,
    output logic                 o_c0_req_rdy,
    input  logic [REQ_TXN_W-1:0] i_c1_req_vec_txn,
    input  logic [REQ_DAT_W-1:0] i_c1_req_vec_dat,
    input  logic                 i_c1_req_vld,
    output logic                 o_c1_req_rdy,

    output logic [RES_TXN_W-1:0] o_c0_res_vec_txn,
    output logic [RES_DAT_W-1:0] o_c0_res_vec_dat,
    output logic                 o_c0_res_vld,
    input  logic                 i_c0_res_rdy,
    output logic [RES_TXN_W-1:0] o_c1_res_vec_txn,
    output logic [RES_DAT_W-1:0] o_c1_res_vec_dat,
    output logic                 o_c1_res_vld,
    input  logic                 i_c1_res_rdy,

    output logic [REQ_TXN_W-1:0] o_m_req_vec_txn,
    output logic [REQ_DAT_W-1:0] o_m_req_vec_dat,
    output logic                 o_m_req_vld,
    input  logic                 i_m_req_rdy,
    input  logic [RES_TXN_W-1:0] i_m_res_vec_txn,
    input  logic [RES_DAT_W-1:0] i_m_res_vec_dat,
    input  logic                 i_m_res_vld,
    output logic                 o_m_res_rdy
);

    if (OSTD_MAX == 0) begin : g_bad_cfg
        $error("vxe_txn_arbiter: OSTD_MAX must be at least 1");
    end

    logic [1:0] req_vld;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic [1:0] req_rdy;
    logic [1:0] res_hs;
    logic       loadable;
    logic       accept;
    cli_e       ptr;
    cli_e       winner;

    assign req_vld  = {i_c1_req_vld, i_c0_req_vld};
    assign loadable = !o_m_req_vld || i_m_req_rdy;
    assign req_rdy  = grant & {2{loadable}};
    assign accept   = (req_rdy != '0);
    assign winner   = grant[1] ? CLI_C1 : CLI_C0;

    assign o_c0_req_rdy = req_rdy[0];
    assign o_c1_req_rdy = req_rdy[1];

    vxe_txnarb_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .advance  (loadable),
        .grant    (grant),
        .ptr      (ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_m_req_vld     <= 1'b0;
            o_m_req_vec_txn <= '0;
            o_m_req_vec_dat <= '0;
        end else if (loadable) begin
            o_m_req_vld <= accept;
            if (accept) begin
                o_m_req_vec_txn <= (winner == CLI_C1) ? tag_txn(i_c1_req_vec_txn, CLI_C1)
                                                      : tag_txn(i_c0_req_vec_txn, CLI_C0);
                o_m_req_vec_dat <= (winner == CLI_C1) ? i_c1_req_vec_dat : i_c0_req_vec_dat;
            end
        end
    end

    logic res_sel;
    assign res_sel = i_m_res_vec_txn[RES_CLI_BIT];

    assign o_c0_res_vec_txn = i_m_res_vec_txn;
    assign o_c1_res_vec_txn = i_m_res_vec_txn;
    assign o_c0_res_vec_dat = i_m_res_vec_dat;
    assign o_c1_res_vec_dat = i_m_res_vec_dat;
    assign o_c0_res_vld     = i_m_res_vld && !res_sel;
    assign o_c1_res_vld     = i_m_res_vld &&  res_sel;
    assign o_m_res_rdy      = res_sel ? i_c1_res_rdy : i_c0_res_rdy;
    assign res_hs           = {o_c1_res_vld && i_c1_res_rdy, o_c0_res_vld && i_c0_res_rdy};

`ifdef VXE_TXNARB_OSTD_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(OSTD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSTD_MAX);

    logic [CNT_W-1:0] ostd_cnt [2];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            eligible[i] = req_vld[i] && (ostd_cnt[i] != CNT_MAX);
        end
    end

    // Decrement saturates at zero so responses outliving a reset are harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                ostd_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (req_rdy[i] && !res_hs[i]) begin
                    ostd_cnt[i] <= ostd_cnt[i] + 1'b1;
                end else if (res_hs[i] && !req_rdy[i] && (ostd_cnt[i] != '0)) begin
                    ostd_cnt[i] <= ostd_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    logic unused_res_hs;
    assign unused_res_hs = ^res_hs;
    assign eligible      = req_vld;
`endif

endmodule

// File: tb/tb_vxe_txn_arbiter.sv
// Directed self-checking bench for vxe_txn_arbiter; the outstanding-limit
// section runs only when VXE_TXNARB_OSTD_LIMIT_EN is defined.
module tb_vxe_txn_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [43:0]  c0_txn, c1_txn;
    logic [71:0]  c0_dat, c1_dat;
    logic         c0_vld, c1_vld;
    logic         c0_rdy, c1_rdy;
    logic [8:0]   c0_res_txn, c1_res_txn;
    logic [63:0]  c0_res_dat, c1_res_dat;
    logic         c0_res_vld, c1_res_vld;
    logic         c0_res_rdy, c1_res_rdy;
    logic [43:0]  m_txn;
    logic [71:0]  m_dat;
    logic         m_vld;
    logic         m_rdy;
    logic [8:0]   m_res_txn;
    logic [63:0]  m_res_dat;
    logic         m_res_vld;
    logic         m_res_rdy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [43:0] SGL_TXN  = {6'h05, 1'b0, 37'h03_0303_0303};
    localparam logic [71:0] SGL_DAT  = {64'hfefe_fafa_dada_dede, 8'h33};
    localparam logic [43:0] A_TXN    = {6'h23, 1'b1, 37'h00_1111_2222};
    localparam logic [43:0] A_TXN_M  = {6'h03, 1'b1, 37'h00_1111_2222};
    localparam logic [71:0] A_DAT    = {64'h0123_4567_89ab_cdef, 8'hff};
    localparam logic [43:0] B_TXN    = {6'h0a, 1'b0, 37'h1f_0000_abcd};
    localparam logic [43:0] B_TXN_M  = {6'h2a, 1'b0, 37'h1f_0000_abcd};
    localparam logic [71:0] B_DAT    = {64'h5555_aaaa_3333_cccc, 8'h0f};
    localparam logic [8:0]  R1_TXN   = {6'h2a, 1'b1, 2'b10};
    localparam logic [63:0] R1_DAT   = 64'hdede_dada_fafa_fefe;
    localparam logic [8:0]  R0_TXN   = {6'h05, 1'b0, 2'b00};
    localparam logic [63:0] R0_DAT   = 64'h1111_2222_3333_4444;

    vxe_txn_arbiter #(.OSTD_MAX(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_c0_req_vec_txn (c0_txn),
        .i_c0_req_vec_dat (c0_dat),
        .i_c0_req_vld     (c0_vld),
        .o_c0_req_rdy     (c0_rdy),
        .i_c1_req_vec_txn (c1_txn),
        .i_c1_req_vec_dat (c1_dat),
        .i_c1_req_vld     (c1_vld),
        .o_c1_req_rdy     (c1_rdy),
        .o_c0_res_vec_txn (c0_res_txn),
        .o_c0_res_vec_dat (c0_res_dat),
        .o_c0_res_vld     (c0_res_vld),
        .i_c0_res_rdy     (c0_res_rdy),
        .o_c1_res_vec_txn (c1_res_txn),
        .o_c1_res_vec_dat (c1_res_dat),
        .o_c1_res_vld     (c1_res_vld),
        .i_c1_res_rdy     (c1_res_rdy),
        .o_m_req_vec_txn  (m_txn),
        .o_m_req_vec_dat  (m_dat),
        .o_m_req_vld      (m_vld),
        .i_m_req_rdy      (m_rdy),
        .i_m_res_vec_txn  (m_res_txn),
        .i_m_res_vec_dat  (m_res_dat),
        .i_m_res_vld      (m_res_vld),
        .o_m_res_rdy      (m_res_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        c0_txn = '0; c0_dat = '0; c0_vld = 1'b0;
        c1_txn = '0; c1_dat = '0; c1_vld = 1'b0;
        c0_res_rdy = 1'b0; c1_res_rdy = 1'b0;
        m_rdy = 1'b0;
        m_res_txn = '0; m_res_dat = '0; m_res_vld = 1'b0;
        #2;
        check("rst_m_vld", m_vld, 1'b0);
        check("rst_m_txn", m_txn, 44'h0);
        check("rst_m_dat", m_dat, 72'h0);
        check("rst_req_rdy", {c1_rdy, c0_rdy}, 2'b00);
        check("rst_res_vld", {c1_res_vld, c0_res_vld}, 2'b00);
        check("rst_m_res_rdy", m_res_rdy, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Contention: c0 first after reset, then strict alternation
        c0_txn = A_TXN; c0_dat = A_DAT; c0_vld = 1'b1;
        c1_txn = B_TXN; c1_dat = B_DAT; c1_vld = 1'b1;
        m_rdy  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_rdy", {c1_rdy, c0_rdy}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("cont_m_vld", m_vld, 1'b1);
            check("cont_m_txn", m_txn, (k % 2 == 0) ? A_TXN_M : B_TXN_M);
            check("cont_m_dat", m_dat, (k % 2 == 0) ? A_DAT : B_DAT);
        end

        // Asynchronous reset while m_reg is full
        c0_vld = 1'b0; c1_vld = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_m_vld", m_vld, 1'b0);
        check("arst_m_txn", m_txn, 44'h0);
        rst = 1'b0;
        c0_txn = SGL_TXN; c0_dat = SGL_DAT; c0_vld = 1'b1;
        c1_vld = 1'b1;
        #1;
        check("post_rst_rdy", {c1_rdy, c0_rdy}, 2'b01);
        tick();
        check("single_m_vld", m_vld, 1'b1);
        check("single_m_txn", m_txn, SGL_TXN);
        check("single_m_dat", m_dat, SGL_DAT);

        // Backpressure: payload held, no grants, then c1 wins on release
        m_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rdy", {c1_rdy, c0_rdy}, 2'b00);
            tick();
            check("bp_m_vld", m_vld, 1'b1);
            check("bp_m_txn", m_txn, SGL_TXN);
            check("bp_m_dat", m_dat, SGL_DAT);
        end
        m_rdy = 1'b1;
        #1;
        check("rel_rdy", {c1_rdy, c0_rdy}, 2'b10);
        tick();
        check("rel_m_txn", m_txn, B_TXN_M);
        check("rel_m_dat", m_dat, B_DAT);
        c0_vld = 1'b0; c1_vld = 1'b0;
        tick();
        check("drain_m_vld", m_vld, 1'b0);

        // Response routing to c1
        m_res_txn = R1_TXN; m_res_dat = R1_DAT; m_res_vld = 1'b1;
        c0_res_rdy = 1'b0; c1_res_rdy = 1'b1;
        #1;
        check("r1_vld", {c1_res_vld, c0_res_vld}, 2'b10);
        check("r1_m_rdy_hi", m_res_rdy, 1'b1);
        check("r1_c1_txn", c1_res_txn, R1_TXN);
        check("r1_c0_txn", c0_res_txn, R1_TXN);
        check("r1_c1_dat", c1_res_dat, R1_DAT);
        c1_res_rdy = 1'b0; c0_res_rdy = 1'b1;
        #1;
        check("r1_m_rdy_lo", m_res_rdy, 1'b0);
        tick();

        // Response routing to c0
        m_res_txn = R0_TXN; m_res_dat = R0_DAT;
        c0_res_rdy = 1'b0; c1_res_rdy = 1'b1;
        #1;
        check("r0_vld", {c1_res_vld, c0_res_vld}, 2'b01);
        check("r0_m_rdy_lo", m_res_rdy, 1'b0);
        check("r0_c0_dat", c0_res_dat, R0_DAT);
        c0_res_rdy = 1'b1;
        #1;
        check("r0_m_rdy_hi", m_res_rdy, 1'b1);
        m_res_vld = 1'b0; c0_res_rdy = 1'b0; c1_res_rdy = 1'b0;
        #1;
        check("r_idle_vld", {c1_res_vld, c0_res_vld}, 2'b00);
        tick();

`ifdef VXE_TXNARB_OSTD_LIMIT_EN
        // Outstanding limit with OSTD_MAX=2 on c0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        c0_txn = SGL_TXN; c0_dat = SGL_DAT; c0_vld = 1'b1;
        m_rdy = 1'b1;
        #1;
        check("lim_rdy_0", c0_rdy, 1'b1);
        tick();
        check("lim_rdy_1", c0_rdy, 1'b1);
        tick();
        check("lim_full", c0_rdy, 1'b0);
        tick();
        check("lim_full_hold", c0_rdy, 1'b0);
        m_res_txn = R0_TXN; m_res_dat = R0_DAT; m_res_vld = 1'b1; c0_res_rdy = 1'b1;
        tick();
        m_res_vld = 1'b0; c0_res_rdy = 1'b0;
        #1;
        check("lim_restored", c0_rdy, 1'b1);
        m_res_vld = 1'b1; c0_res_rdy = 1'b1;
        tick();
        m_res_vld = 1'b0; c0_res_rdy = 1'b0;
        #1;
        check("lim_simul_unchanged", c0_rdy, 1'b1);
        tick();
        check("lim_full_again", c0_rdy, 1'b0);
        c0_vld = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
